// File: rtl/sc_lane_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sc_lane_shift_sequencer
// Purpose : Clear/load/shift command sequencer for the lane background registers.
// Revision: 1.0
// ============================================================================
module sc_lane_shift_sequencer #(
  parameter int CNT_WIDTH = 26,
  parameter int PERIOD_L1 = 25000000,
  parameter int PERIOD_L2 = 18750000,
  parameter int PERIOD_L3 = 12500000,
  parameter int PERIOD_L4 = 6250000
) (
  input  logic       SC_LaneSeq_CLOCK_50,
  input  logic       SC_LaneSeq_RESET_InHigh,
  input  logic       SC_LaneSeq_start_InLow,
  input  logic       SC_LaneSeq_levelup_InLow,
  input  logic       SC_LaneSeq_gameover_InLow,
  input  logic       SC_LaneSeq_pause_InHigh,
  input  logic       SC_LaneSeq_direction_In,
  output logic       SC_LaneSeq_clear_OutLow,
  output logic       SC_LaneSeq_load_OutLow,
  output logic [1:0] SC_LaneSeq_shiftselection_OutBUS,
  output logic [1:0] SC_LaneSeq_level_OutBUS,
  output logic       SC_LaneSeq_running_Out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_LOAD  = 3'd4,
    S_OVER  = 3'd5
  } state_e;

  localparam logic [CNT_WIDTH-1:0] c_TC_L1   = CNT_WIDTH'(PERIOD_L1 - 1);
  localparam logic [CNT_WIDTH-1:0] c_TC_L2   = CNT_WIDTH'(PERIOD_L2 - 1);
  localparam logic [CNT_WIDTH-1:0] c_TC_L3   = CNT_WIDTH'(PERIOD_L3 - 1);
  localparam logic [CNT_WIDTH-1:0] c_TC_L4   = CNT_WIDTH'(PERIOD_L4 - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           level_q, level_d;
  logic                 armed_q, armed_d;
  logic                 clear_q, clear_d;
  logic                 load_q, load_d;
  logic [1:0]           shsel_q, shsel_d;
  logic                 running_q, running_d;
  logic [CNT_WIDTH-1:0] w_tc;
  logic                 w_levelup;

  always_comb begin
    case (level_q)
      2'd0:    w_tc = c_TC_L1;
      2'd1:    w_tc = c_TC_L2;
      2'd2:    w_tc = c_TC_L3;
      default: w_tc = c_TC_L4;
    endcase
  end

  // A levelup counts only after the input has been seen high since the last accept/CLEAR.
  assign w_levelup = ~SC_LaneSeq_levelup_InLow & armed_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q | SC_LaneSeq_levelup_InLow;
    clear_d = 1'b1;
    load_d  = 1'b1;
    shsel_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (!SC_LaneSeq_start_InLow) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clear_d = 1'b0;
        level_d = 2'd0;
        cnt_d   = '0;
        armed_d = SC_LaneSeq_levelup_InLow;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!SC_LaneSeq_gameover_InLow) begin
          state_d = S_OVER;
        end else if (w_levelup) begin
          state_d = S_LOAD;
          armed_d = 1'b0;
        end else if (SC_LaneSeq_pause_InHigh) begin
          state_d = S_PAUSE;
        end else if (cnt_q == w_tc) begin
          cnt_d   = '0;
          shsel_d = SC_LaneSeq_direction_In ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      S_PAUSE: begin
        if (!SC_LaneSeq_gameover_InLow)   state_d = S_OVER;
        else if (!SC_LaneSeq_pause_InHigh) state_d = S_RUN;
      end
      S_LOAD: begin
        load_d  = 1'b0;
        level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_OVER: begin
        if (!SC_LaneSeq_start_InLow) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge SC_LaneSeq_CLOCK_50) begin
    if (SC_LaneSeq_RESET_InHigh) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      level_q   <= 2'd0;
      armed_q   <= 1'b0;
      clear_q   <= 1'b1;
      load_q    <= 1'b1;
      shsel_q   <= 2'b00;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      armed_q   <= armed_d;
      clear_q   <= clear_d;
      load_q    <= load_d;
      shsel_q   <= shsel_d;
      running_q <= running_d;
    end
  end

  assign SC_LaneSeq_clear_OutLow          = clear_q;
  assign SC_LaneSeq_load_OutLow           = load_q;
  assign SC_LaneSeq_shiftselection_OutBUS = shsel_q;
  assign SC_LaneSeq_level_OutBUS          = level_q;
  assign SC_LaneSeq_running_Out           = running_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_lane_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sc_lane_shift_sequencer
// Purpose : Scoreboard bench for sc_lane_shift_sequencer with a game-rule model.
// Revision: 1.0
// ============================================================================
module tb_sc_lane_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       levelup_n = 1'b1;
  logic       gameover_n = 1'b1;
  logic       pause = 1'b0;
  logic       dir = 1'b0;
  logic       clr_n, ld_n, running;
  logic [1:0] shsel, level;

  typedef struct packed {
    logic       clr;
    logic       ld;
    logic [1:0] sh;
    logic [1:0] lvl;
    logic       run;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_LOAD  = 4;
  localparam int M_OVER  = 5;

  sc_lane_shift_sequencer #(
    .CNT_WIDTH(8), .PERIOD_L1(4), .PERIOD_L2(3), .PERIOD_L3(2), .PERIOD_L4(2)
  ) dut (
    .SC_LaneSeq_CLOCK_50             (clk),
    .SC_LaneSeq_RESET_InHigh         (rst),
    .SC_LaneSeq_start_InLow          (start_n),
    .SC_LaneSeq_levelup_InLow        (levelup_n),
    .SC_LaneSeq_gameover_InLow       (gameover_n),
    .SC_LaneSeq_pause_InHigh         (pause),
    .SC_LaneSeq_direction_In         (dir),
    .SC_LaneSeq_clear_OutLow         (clr_n),
    .SC_LaneSeq_load_OutLow          (ld_n),
    .SC_LaneSeq_shiftselection_OutBUS(shsel),
    .SC_LaneSeq_level_OutBUS         (level),
    .SC_LaneSeq_running_Out          (running)
  );

  always #5 clk = ~clk;

  // Reference model: game rules evaluated on each edge; the outputs it predicts
  // are what the lane registers should see during the following cycle.
  initial begin
    int   mode, lvl, elapsed;
    bit   armed, accept, was_clear;
    int   period[4];
    exp_t e;
    period = '{4, 3, 2, 2};
    mode = M_IDLE; lvl = 0; elapsed = 0; armed = 1'b0;
    forever begin
      @(posedge clk);
      n_cyc++;
      e = '{clr: 1'b1, ld: 1'b1, sh: 2'b00, lvl: 2'b00, run: 1'b0};
      if (rst) begin
        mode = M_IDLE; lvl = 0; elapsed = 0; armed = 1'b0;
      end else begin
        accept    = 1'b0;
        was_clear = (mode == M_CLEAR);
        case (mode)
          M_IDLE:  if (!start_n) mode = M_CLEAR;
          M_CLEAR: begin
            e.clr = 1'b0; lvl = 0; elapsed = 0; mode = M_RUN;
          end
          M_RUN: begin
            if (!gameover_n) mode = M_OVER;
            else if (!levelup_n && armed) begin
              accept = 1'b1; mode = M_LOAD;
            end else if (pause) mode = M_PAUSE;
            else begin
              elapsed++;
              if (elapsed == period[lvl]) begin
                elapsed = 0;
                e.sh = dir ? 2'b10 : 2'b01;
              end
            end
          end
          M_PAUSE: begin
            if (!gameover_n) mode = M_OVER;
            else if (!pause) mode = M_RUN;
          end
          M_LOAD: begin
            e.ld = 1'b0; lvl = (lvl < 3) ? lvl + 1 : 3; elapsed = 0; mode = M_RUN;
          end
          default: if (!start_n) mode = M_CLEAR;
        endcase
        armed = levelup_n ? 1'b1 : (armed && !was_clear && !accept);
      end
      e.lvl = 2'(lvl);
      e.run = (mode == M_RUN);
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle is a transaction; compare against the oldest prediction.
  initial begin
    exp_t e, a;
    int   active;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{clr: clr_n, ld: ld_n, sh: shsel, lvl: level, run: running};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc%0d: got clr=%b ld=%b sh=%b lvl=%0d run=%b, expected clr=%b ld=%b sh=%b lvl=%0d run=%b",
                   n_cyc, a.clr, a.ld, a.sh, a.lvl, a.run, e.clr, e.ld, e.sh, e.lvl, e.run);
        end
        active = int'(!clr_n) + int'(!ld_n) + int'(shsel != 2'b00);
        n_tests++;
        if (active > 1) begin
          n_fail++;
          $display("FAIL mutex cyc%0d: got %0d simultaneous commands, expected at most 1", n_cyc, active);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_n = 1'b0; cyc(1); start_n = 1'b1;
  endtask

  initial begin
    // Reset, start, left scroll at level 0
    cyc(3);
    rst = 1'b0;
    pulse_start();
    cyc(20);
    // Right scroll with a pause in the middle of a period
    dir = 1'b1;
    cyc(6);
    pause = 1'b1; cyc(10); pause = 1'b0;
    cyc(12);
    // Four level-ups, last one saturating at level 3
    for (int i = 0; i < 4; i++) begin
      levelup_n = 1'b0; cyc(1); levelup_n = 1'b1;
      cyc(8);
    end
    // Simultaneous levelup and gameover, then ignored requests in OVER
    levelup_n = 1'b0; gameover_n = 1'b0; cyc(1);
    levelup_n = 1'b1; gameover_n = 1'b1; cyc(3);
    pause = 1'b1; levelup_n = 1'b0; cyc(2);
    pause = 1'b0; levelup_n = 1'b1; cyc(3);
    pulse_start();
    cyc(6);
    // Reset landing in the load-pulse cycle
    levelup_n = 1'b0; cyc(1); levelup_n = 1'b1; cyc(1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    cyc(3);
    // Held levelup yields one load only
    pulse_start();
    cyc(5);
    levelup_n = 1'b0; cyc(20); levelup_n = 1'b1;
    cyc(10);
    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      start_n    = ($urandom_range(0, 29) != 0);
      gameover_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 5) == 0) levelup_n = ~levelup_n;
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 3) == 0) dir = 1'($urandom_range(0, 1));
      cyc(1);
    end
    rst = 1'b0; start_n = 1'b1; gameover_n = 1'b1; levelup_n = 1'b1; pause = 1'b0;
    cyc(4);
    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked predictions, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
